// File: rtl/regfile_pkg.sv
// Shared constants for the 8x16 register file and its read-side controller.
// Holds the storage geometry defaults, the FSM encoding and the length clamp.
package regfile_pkg;

    localparam int RF_WIDTH  = 16;
    localparam int RF_DEPTH  = 8;
    localparam int RF_ADDR_W = 3;

    localparam int RF_LEN_MAX = RF_DEPTH;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_READ = 2'd1;
    localparam logic [1:0] ST_ERR  = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE = ST_IDLE,
        S_READ = ST_READ,
        S_ERR  = ST_ERR
    } rd_state_t;

    // 0 means a single word; anything past the file size reads it once.
    function automatic int eff_len(input int len, input int depth);
        if (len == 0) return 1;
        if (len > depth) return depth;
        return len;
    endfunction

endpackage

// File: rtl/regfile_rsp_stage.sv
// One-entry response register with valid/ready handshake.
// Loads when told to, holds under backpressure, clears once drained.
module regfile_rsp_stage #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_last,
    input  logic             i_err,
    input  logic             i_ready,
    output logic             o_free,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data,
    output logic             o_last,
    output logic             o_err
);

    logic             r_valid;
    logic [WIDTH-1:0] r_data;
    logic             r_last;
    logic             r_err;

    assign o_free  = !r_valid || i_ready;
    assign o_valid = r_valid;
    assign o_data  = r_data;
    assign o_last  = r_last;
    assign o_err   = r_err;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_last  <= 1'b0;
            r_err   <= 1'b0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_data  <= i_data;
            r_last  <= i_last;
            r_err   <= i_err;
        end else if (i_ready) begin
            r_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/regfile_burst_reader.sv
// Read-side burst controller for the register file storage.
// Walks addresses modulo DEPTH and streams words through the response stage.
module regfile_burst_reader
    import regfile_pkg::*;
#(
    parameter int WIDTH  = RF_WIDTH,
    parameter int DEPTH  = RF_DEPTH,
    parameter int ADDR_W = RF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [ADDR_W:0]   req_len,
    output logic [ADDR_W-1:0] rf_rd_addr,
    input  logic [WIDTH-1:0]  rf_rd_data,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [WIDTH-1:0]  rsp_data,
    output logic              rsp_last,
    output logic              rsp_err,
    output logic              busy
);

    localparam int CNT_W = ADDR_W + 1;

    rd_state_t         r_state;
    rd_state_t         w_state_nxt;
    logic [ADDR_W-1:0] r_addr;
    logic [CNT_W-1:0]  r_cnt;

    logic              w_free;
    logic              w_load;
    logic [WIDTH-1:0]  w_ld_data;
    logic              w_ld_last;
    logic              w_ld_err;
    logic              w_addr_bad;
    logic [CNT_W-1:0]  w_len_eff;
    logic [ADDR_W-1:0] w_addr_inc;

    assign w_addr_bad = int'(req_addr) >= DEPTH;
    assign w_len_eff  = CNT_W'(eff_len(int'(req_len), DEPTH));
    assign w_addr_inc = (r_addr == ADDR_W'(DEPTH - 1)) ? '0
                                                        : r_addr + ADDR_W'(1);
    assign rf_rd_addr = r_addr;
    assign busy       = (r_state != S_IDLE) || rsp_valid;

    always_comb begin
        w_state_nxt = r_state;
        req_ready   = 1'b0;
        w_load      = 1'b0;
        w_ld_data   = rf_rd_data;
        w_ld_last   = 1'b0;
        w_ld_err    = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid)
                    w_state_nxt = w_addr_bad ? S_ERR : S_READ;
            end
            S_READ: begin
                if (w_free) begin
                    w_load    = 1'b1;
                    w_ld_last = (r_cnt == CNT_W'(1));
                    if (w_ld_last)
                        w_state_nxt = S_IDLE;
                end
            end
            S_ERR: begin
                if (w_free) begin
                    w_load      = 1'b1;
                    w_ld_data   = '0;
                    w_ld_last   = 1'b1;
                    w_ld_err    = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Address and count only move on an accepted request or a captured beat.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_addr  <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == S_IDLE && req_valid) begin
                r_addr <= req_addr;
                r_cnt  <= w_len_eff;
            end else if (r_state == S_READ && w_load) begin
                r_addr <= w_addr_inc;
                r_cnt  <= r_cnt - CNT_W'(1);
            end
        end
    end

    regfile_rsp_stage #(
        .WIDTH (WIDTH)
    ) u_rsp (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_load),
        .i_data  (w_ld_data),
        .i_last  (w_ld_last),
        .i_err   (w_ld_err),
        .i_ready (rsp_ready),
        .o_free  (w_free),
        .o_valid (rsp_valid),
        .o_data  (rsp_data),
        .o_last  (rsp_last),
        .o_err   (rsp_err)
    );

endmodule

// File: tb/tb_regfile_burst_reader.sv
// Randomized and directed bench for regfile_burst_reader.
// A queue model predicts beats per request from storage contents at accept.
module tb_regfile_burst_reader;

    localparam int W  = 16;
    localparam int D  = 8;
    localparam int AW = 3;
    localparam int DB = 6;

    typedef struct {
        logic [W-1:0] data;
        logic         last;
        logic         err;
    } beat_t;

    logic          clk;
    logic          rst;
    logic          req_valid, req_ready;
    logic [AW-1:0] req_addr;
    logic [AW:0]   req_len;
    logic [AW-1:0] rf_rd_addr;
    logic [W-1:0]  rf_rd_data;
    logic          rsp_valid, rsp_ready, rsp_last, rsp_err, busy;
    logic [W-1:0]  rsp_data;

    logic          b_req_valid, b_req_ready;
    logic [AW-1:0] b_req_addr;
    logic [AW:0]   b_req_len;
    logic [AW-1:0] b_rf_rd_addr;
    logic [W-1:0]  b_rf_rd_data;
    logic          b_rsp_valid, b_rsp_ready, b_rsp_last, b_rsp_err, b_busy;
    logic [W-1:0]  b_rsp_data;

    logic [W-1:0]  mem [8];
    beat_t         exp_q [$];
    int            n_chk = 0;
    int            n_err = 0;
    int            n_beats = 0;
    bit            rand_ready = 0;

    assign rf_rd_data   = mem[rf_rd_addr];
    assign b_rf_rd_data = mem[b_rf_rd_addr];

    regfile_burst_reader #(.WIDTH(W), .DEPTH(D), .ADDR_W(AW)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_len(req_len),
        .rf_rd_addr(rf_rd_addr), .rf_rd_data(rf_rd_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_last(rsp_last),
        .rsp_err(rsp_err), .busy(busy)
    );

    regfile_burst_reader #(.WIDTH(W), .DEPTH(DB), .ADDR_W(AW)) dut_b (
        .clk(clk), .rst(rst),
        .req_valid(b_req_valid), .req_ready(b_req_ready),
        .req_addr(b_req_addr), .req_len(b_req_len),
        .rf_rd_addr(b_rf_rd_addr), .rf_rd_data(b_rf_rd_data),
        .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready),
        .rsp_data(b_rsp_data), .rsp_last(b_rsp_last),
        .rsp_err(b_rsp_err), .busy(b_busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected beats follow directly from start, length and file contents.
    task automatic model_push(input int a, input int l, input int depth);
        beat_t b;
        int    n;
        if (a >= depth) begin
            b.data = '0; b.last = 1'b1; b.err = 1'b1;
            exp_q.push_back(b);
        end else begin
            n = (l == 0) ? 1 : ((l > depth) ? depth : l);
            for (int i = 0; i < n; i++) begin
                b.data = mem[(a + i) % depth];
                b.last = (i == n - 1);
                b.err  = 1'b0;
                exp_q.push_back(b);
            end
        end
    endtask

    task automatic send_req(input int a, input int l);
        int n;
        n = 0;
        req_valid = 1'b1;
        req_addr  = AW'(a);
        req_len   = (AW+1)'(l);
        @(negedge clk);
        while (!req_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("req_accept_timeout", {31'd0, req_ready}, 1);
        model_push(a, l, D);
        tick();
        req_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || busy) && n < 500) begin
            tick();
            n++;
        end
        chk("drain_timeout", {31'd0, n < 500}, 1);
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (rand_ready) rsp_ready = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        logic         prev_stall;
        logic [W-1:0] prev_data;
        logic         prev_last;
        prev_stall = 1'b0;
        prev_data  = '0;
        prev_last  = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    chk("hold_valid", {31'd0, rsp_valid}, 1);
                    chk("hold_data", {16'd0, rsp_data}, {16'd0, prev_data});
                    chk("hold_last", {31'd0, rsp_last}, {31'd0, prev_last});
                end
                if (rsp_valid && rsp_ready) begin
                    n_beats++;
                    chk("beat_expected", {31'd0, exp_q.size() != 0}, 1);
                    if (exp_q.size() != 0) begin
                        beat_t b;
                        b = exp_q.pop_front();
                        chk("beat_data", {16'd0, rsp_data}, {16'd0, b.data});
                        chk("beat_last", {31'd0, rsp_last}, {31'd0, b.last});
                        chk("beat_err", {31'd0, rsp_err}, {31'd0, b.err});
                    end
                end
                prev_stall = rsp_valid && !rsp_ready;
                prev_data  = rsp_data;
                prev_last  = rsp_last;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int b0;
        rst = 1'b0;
        req_valid = 1'b0; req_addr = '0; req_len = '0; rsp_ready = 1'b1;
        b_req_valid = 1'b0; b_req_addr = '0; b_req_len = '0;
        b_rsp_ready = 1'b1;
        for (int i = 0; i < 8; i++) mem[i] = '0;
        #1 rst = 1'b1;
        #2;
        chk("rst_req_ready", {31'd0, req_ready}, 1);
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 0);
        chk("rst_rsp_data", {16'd0, rsp_data}, 0);
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_rd_addr", {29'd0, rf_rd_addr}, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        tick();
        chk("idle_req_ready", {31'd0, req_ready}, 1);
        chk("idle_rsp_valid", {31'd0, rsp_valid}, 0);
        chk("idle_last_err", {30'd0, rsp_last, rsp_err}, 0);
        chk("idle_busy", {31'd0, busy}, 0);

        mem[5] = 16'hBEEF;
        send_req(5, 1);
        chk("single_latency", {31'd0, rsp_valid}, 0);
        tick();
        chk("single_valid", {31'd0, rsp_valid}, 1);
        chk("single_data", {16'd0, rsp_data}, 32'hBEEF);
        chk("single_last_err", {30'd0, rsp_last, rsp_err}, 2);
        tick();
        chk("single_done_valid", {31'd0, rsp_valid}, 0);
        chk("single_done_busy", {31'd0, busy}, 0);
        chk("single_done_ready", {31'd0, req_ready}, 1);

        for (int i = 0; i < 8; i++) mem[i] = W'(16'h1000 + i);
        send_req(6, 8);
        for (int k = 0; k < 8; k++) begin
            chk("wrap_rd_addr", {29'd0, rf_rd_addr}, (6 + k) % 8);
            tick();
            chk("wrap_valid", {31'd0, rsp_valid}, 1);
            chk("wrap_data", {16'd0, rsp_data}, 32'h1000 + (6 + k) % 8);
            chk("wrap_last", {31'd0, rsp_last}, {31'd0, k == 7});
        end
        tick();
        chk("wrap_done_valid", {31'd0, rsp_valid}, 0);

        b0 = n_beats;
        send_req(0, 3);
        tick();
        chk("bp_beat1", {16'd0, rsp_data}, 32'h1000);
        tick();
        chk("bp_beat2", {16'd0, rsp_data}, 32'h1001);
        rsp_ready = 1'b0;
        repeat (3) begin
            tick();
            chk("bp_hold_valid", {31'd0, rsp_valid}, 1);
            chk("bp_hold_data", {16'd0, rsp_data}, 32'h1001);
        end
        rsp_ready = 1'b1;
        drain();
        chk("bp_beat_count", n_beats - b0, 3);

        b0 = n_beats;
        send_req(3, 0);
        drain();
        chk("len0_beats", n_beats - b0, 1);
        b0 = n_beats;
        send_req(2, 15);
        drain();
        chk("len15_beats", n_beats - b0, 8);

        send_req(0, 8);
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("midrst_valid", {31'd0, rsp_valid}, 0);
        chk("midrst_data", {16'd0, rsp_data}, 0);
        chk("midrst_busy", {31'd0, busy}, 0);
        chk("midrst_ready", {31'd0, req_ready}, 1);
        exp_q.delete();
        tick();
        rst = 1'b0;
        tick();
        b0 = n_beats;
        send_req(1, 2);
        drain();
        chk("post_rst_beats", n_beats - b0, 2);

        for (int i = 0; i < 8; i++) mem[i] = W'($urandom);
        rand_ready = 1'b1;
        for (int r = 0; r < 40; r++) begin
            send_req(int'($urandom_range(0, 7)), int'($urandom_range(0, 15)));
            if ($urandom_range(0, 2) == 0)
                repeat ($urandom_range(1, 6)) tick();
        end
        drain();
        rand_ready = 1'b0;
        tick();
        rsp_ready = 1'b1;

        b_req_valid = 1'b1; b_req_addr = 3'd7; b_req_len = 4'd4;
        tick();
        b_req_valid = 1'b0;
        chk("err_latency", {31'd0, b_rsp_valid}, 0);
        tick();
        chk("err_valid", {31'd0, b_rsp_valid}, 1);
        chk("err_data", {16'd0, b_rsp_data}, 0);
        chk("err_last_err", {30'd0, b_rsp_last, b_rsp_err}, 3);
        tick();
        chk("err_done_valid", {31'd0, b_rsp_valid}, 0);
        chk("err_done_ready", {31'd0, b_req_ready}, 1);
        chk("err_done_busy", {31'd0, b_busy}, 0);

        b_req_valid = 1'b1; b_req_addr = 3'd4; b_req_len = 4'd8;
        tick();
        b_req_valid = 1'b0;
        for (int k = 0; k < DB; k++) begin
            tick();
            chk("d6_data", {16'd0, b_rsp_data}, {16'd0, mem[(4 + k) % DB]});
            chk("d6_last_err", {30'd0, b_rsp_last, b_rsp_err},
                {30'd0, k == DB - 1, 1'b0});
        end
        tick();
        chk("d6_done_valid", {31'd0, b_rsp_valid}, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
